// File: rtl/mips32_pipe_hz.sv
// mips32_pipe_hz: single-clock 5-stage (IF/ID/EX/MEM/WB) MIPS32 subset pipeline
// with a hardware RAW interlock, so dependent instructions need no filler.
// Build macro FORWARD_EN: when defined, EX/MEM->EX and MEM/WB->EX bypass is
// enabled and only load-use stalls. When undefined, the interlock waits for
// the producer to reach WB, where the write-through register read picks it up.
// Pipeline handshake: every stage register carries a valid bit. A cleared valid
// is a bubble. A stall holds pc and IF/ID and pushes a bubble into ID/EX. A taken
// branch in EX overrides the stall and clears the IF/ID and ID/EX valid bits.
module mips32_pipe_hz #(
    parameter int DATA_W = 32,
    parameter int AW     = 10,
    parameter int NREG   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic [31:0]   retired,
    output logic [31:0]   stalls
);
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Unified instruction/data memory and register file; neither is reset.
    logic [DATA_W-1:0] mem  [0:(2**AW)-1];
    logic [DATA_W-1:0] regs [0:NREG-1];

    // IF/ID
    logic              if_id_valid;
    logic [31:0]       if_id_ir;
    logic [AW-1:0]     if_id_pc;
    logic              halt_pend;
    // ID/EX
    logic              id_ex_valid;
    logic [5:0]        id_ex_op;
    logic [AW-1:0]     id_ex_pc;
    logic [DATA_W-1:0] id_ex_a, id_ex_b, id_ex_imm;
    logic [4:0]        id_ex_dst;
    logic              id_ex_wen;
`ifdef FORWARD_EN
    logic [4:0]        id_ex_rs, id_ex_rt;
`endif
    // EX/MEM
    logic              ex_mem_valid;
    logic [5:0]        ex_mem_op;
    logic [DATA_W-1:0] ex_mem_res, ex_mem_sdata;
    logic [4:0]        ex_mem_dst;
    logic              ex_mem_wen;
    // MEM/WB
    logic              mem_wb_valid;
    logic [5:0]        mem_wb_op;
    logic [DATA_W-1:0] mem_wb_res;
    logic [4:0]        mem_wb_dst;
    logic              mem_wb_wen;

    // Decode / EX combinational signals
    logic [5:0]        id_op;
    logic [4:0]        id_rs, id_rt, id_rd, id_dst;
    logic [DATA_W-1:0] id_imm, id_a, id_b;
    logic              id_rtype, id_alui, id_uses_rs, id_uses_rt, id_wen, id_hlt;
    logic              hz_rs, hz_rt, stall, fetch_en, wb_we;
    logic [DATA_W-1:0] ex_a, ex_b, ex_res;
    logic              ex_take;
    logic [AW-1:0]     ex_target;

    assign wb_we    = mem_wb_valid && mem_wb_wen && !halted;
    assign stall    = if_id_valid && (hz_rs || hz_rt);
    assign fetch_en = !ex_take && !stall && !id_hlt && !halt_pend;

    // Decode the IF/ID word and read operands, with write-through from WB
    always_comb begin
        id_op      = if_id_ir[31:26];
        id_rs      = if_id_ir[25:21];
        id_rt      = if_id_ir[20:16];
        id_rd      = if_id_ir[15:11];
        id_imm     = {{(DATA_W-16){if_id_ir[15]}}, if_id_ir[15:0]};
        id_rtype   = (id_op <= OP_MUL);
        id_alui    = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
        id_uses_rs = id_rtype || id_alui || (id_op == OP_LW) || (id_op == OP_SW) ||
                     (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
        id_uses_rt = id_rtype || (id_op == OP_SW);
        id_dst     = id_rtype ? id_rd : id_rt;
        // R0 and out-of-range destinations never write, so never create hazards.
        id_wen     = (id_rtype || id_alui || (id_op == OP_LW)) &&
                     (id_dst != 5'd0) && (int'(id_dst) < NREG);
        id_hlt     = if_id_valid && (id_op == OP_HLT);
        id_a       = '0;
        id_b       = '0;
        if (id_rs != 5'd0 && int'(id_rs) < NREG)
            id_a = (wb_we && mem_wb_dst == id_rs) ? mem_wb_res : regs[id_rs];
        if (id_rt != 5'd0 && int'(id_rt) < NREG)
            id_b = (wb_we && mem_wb_dst == id_rt) ? mem_wb_res : regs[id_rt];
    end

    // RAW hazard detection against older in-flight destinations
    always_comb begin
`ifdef FORWARD_EN
        hz_rs = id_uses_rs && id_ex_valid && id_ex_wen && (id_ex_op == OP_LW) &&
                (id_ex_dst == id_rs);
        hz_rt = id_uses_rt && id_ex_valid && id_ex_wen && (id_ex_op == OP_LW) &&
                (id_ex_dst == id_rt);
`else
        hz_rs = id_uses_rs && ((id_ex_valid && id_ex_wen && id_ex_dst == id_rs) ||
                               (ex_mem_valid && ex_mem_wen && ex_mem_dst == id_rs));
        hz_rt = id_uses_rt && ((id_ex_valid && id_ex_wen && id_ex_dst == id_rt) ||
                               (ex_mem_valid && ex_mem_wen && ex_mem_dst == id_rt));
`endif
    end

    // EX: operand bypass (youngest first), ALU and branch resolution
    always_comb begin
        ex_a = id_ex_a;
        ex_b = id_ex_b;
`ifdef FORWARD_EN
        if (ex_mem_valid && ex_mem_wen && ex_mem_dst == id_ex_rs)      ex_a = ex_mem_res;
        else if (mem_wb_valid && mem_wb_wen && mem_wb_dst == id_ex_rs) ex_a = mem_wb_res;
        if (ex_mem_valid && ex_mem_wen && ex_mem_dst == id_ex_rt)      ex_b = ex_mem_res;
        else if (mem_wb_valid && mem_wb_wen && mem_wb_dst == id_ex_rt) ex_b = mem_wb_res;
`endif
        case (id_ex_op)
            OP_ADD:                ex_res = ex_a + ex_b;
            OP_SUB:                ex_res = ex_a - ex_b;
            OP_AND:                ex_res = ex_a & ex_b;
            OP_OR:                 ex_res = ex_a | ex_b;
            OP_SLT:                ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
            OP_MUL:                ex_res = ex_a * ex_b;
            OP_ADDI, OP_LW, OP_SW: ex_res = ex_a + id_ex_imm;
            OP_SUBI:               ex_res = ex_a - id_ex_imm;
            OP_SLTI:               ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(id_ex_imm))};
            default:               ex_res = '0;
        endcase
        ex_take   = id_ex_valid && (((id_ex_op == OP_BEQZ) && (ex_a == '0)) ||
                                    ((id_ex_op == OP_BNEQZ) && (ex_a != '0)));
        ex_target = id_ex_pc + AW'(1) + id_ex_imm[AW-1:0];
    end

    // Front end: pc, IF/ID valid, and the sticky fetch stop after a decoded HLT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            if_id_valid <= 1'b0;
            halt_pend   <= 1'b0;
        end else if (ex_take) begin
            pc          <= ex_target;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if (id_hlt || halt_pend) begin
                if_id_valid <= 1'b0;
                halt_pend   <= 1'b1;
            end else begin
                if_id_valid <= 1'b1;
                pc          <= pc + AW'(1);
            end
        end
    end

    // Instruction capture into IF/ID; contents only matter while valid
    always_ff @(posedge clk) begin
        if (fetch_en) begin
            if_id_ir <= mem[pc][31:0];
            if_id_pc <= pc;
        end
    end

    // Valid bits of the back-end stages; bubbles injected by stall or squash
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid  <= 1'b0;
            ex_mem_valid <= 1'b0;
            mem_wb_valid <= 1'b0;
        end else begin
            id_ex_valid  <= if_id_valid && !ex_take && !stall;
            ex_mem_valid <= id_ex_valid;
            mem_wb_valid <= ex_mem_valid;
        end
    end

    // Back-end data path registers, qualified by the valid bits above
    always_ff @(posedge clk) begin
        id_ex_op     <= id_op;
        id_ex_pc     <= if_id_pc;
        id_ex_a      <= id_a;
        id_ex_b      <= id_b;
        id_ex_imm    <= id_imm;
        id_ex_dst    <= id_dst;
        id_ex_wen    <= id_wen;
`ifdef FORWARD_EN
        id_ex_rs     <= id_rs;
        id_ex_rt     <= id_rt;
`endif
        ex_mem_op    <= id_ex_op;
        ex_mem_res   <= ex_res;
        ex_mem_sdata <= ex_b;
        ex_mem_dst   <= id_ex_dst;
        ex_mem_wen   <= id_ex_wen;
        mem_wb_op    <= ex_mem_op;
        mem_wb_res   <= (ex_mem_op == OP_LW) ? mem[ex_mem_res[AW-1:0]] : ex_mem_res;
        mem_wb_dst   <= ex_mem_dst;
        mem_wb_wen   <= ex_mem_wen;
    end

    // Store in MEM; suppressed once the core has halted
    always_ff @(posedge clk) begin
        if (ex_mem_valid && (ex_mem_op == OP_SW) && !halted)
            mem[ex_mem_res[AW-1:0]] <= ex_mem_sdata;
    end

    // Register write-back in WB
    always_ff @(posedge clk) begin
        if (wb_we)
            regs[mem_wb_dst] <= mem_wb_res;
    end

    // Retire/stall counters and the sticky halted flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted  <= 1'b0;
            retired <= '0;
            stalls  <= '0;
        end else if (!halted) begin
            if (mem_wb_valid) begin
                retired <= retired + 32'd1;
                if (mem_wb_op == OP_HLT)
                    halted <= 1'b1;
            end
            if (stall && !ex_take)
                stalls <= stalls + 32'd1;
        end
    end
endmodule

// File: tb/tb_mips32_pipe_hz.sv
// tb_mips32_pipe_hz: directed programs with hand-computed results for
// mips32_pipe_hz. Expected stall counts and halt edges follow FORWARD_EN.
module tb_mips32_pipe_hz;
    localparam int AW = 10;

`ifdef FORWARD_EN
    localparam int EXP_S1    = 0;
    localparam int EXP_E1    = 10;
    localparam int EXP_LU    = 1;
    localparam int EXP_ALU_S = 0;
`else
    localparam int EXP_S1    = 3;
    localparam int EXP_E1    = 13;
    localparam int EXP_LU    = 2;
    localparam int EXP_ALU_S = 2;
`endif
    localparam logic [31:0] HLT = 32'hFC000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc;
    logic          halted;
    logic [31:0]   retired;
    logic [31:0]   stalls;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            edges;
    logic [AW-1:0] pc_snap;

    // clock / reset
    always #5 clk = ~clk;

    mips32_pipe_hz #(.DATA_W(32), .AW(AW), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .halted(halted),
        .retired(retired), .stalls(stalls)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic hold_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2**AW; i++) dut.mem[i] = 32'h0;
    endtask

    task automatic go();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(output int n);
        n = 0;
        while (!halted && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("halt_seen", {31'b0, halted}, 32'd1);
    endtask

    initial begin
        // Independent ADDIs feeding a dependent ADD chain
        hold_reset();
        check("rst_pc", {22'b0, pc}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_stalls", stalls, 32'd0);
        dut.mem[0] = 32'h2801000A;
        dut.mem[1] = 32'h28020014;
        dut.mem[2] = 32'h28030019;
        dut.mem[3] = 32'h00222000;
        dut.mem[4] = 32'h00832800;
        dut.mem[5] = HLT;
        go();
        run_to_halt(edges);
        check("p1_edges", edges, EXP_E1);
        check("p1_r4", dut.regs[4], 32'd30);
        check("p1_r5", dut.regs[5], 32'd55);
        check("p1_retired", retired, 32'd6);
        check("p1_stalls", stalls, EXP_S1);

        // Load-use
        hold_reset();
        dut.regs[1] = 32'd20; dut.regs[2] = 32'd0; dut.regs[3] = 32'd0;
        dut.mem[0] = 32'h20220000;
        dut.mem[1] = 32'h00421800;
        dut.mem[2] = HLT;
        dut.mem[20] = 32'd7;
        go();
        run_to_halt(edges);
        check("lu_r2", dut.regs[2], 32'd7);
        check("lu_r3", dut.regs[3], 32'd14);
        check("lu_stalls", stalls, EXP_LU);
        check("lu_retired", retired, 32'd3);

        // Taken BEQZ squashes two younger instructions
        hold_reset();
        dut.regs[1] = 32'd0; dut.regs[5] = 32'h77; dut.regs[6] = 32'd0;
        dut.mem[0] = 32'h38200002;
        dut.mem[1] = 32'h28050001;
        dut.mem[2] = 32'h28050002;
        dut.mem[3] = 32'h28060003;
        dut.mem[4] = HLT;
        go();
        run_to_halt(edges);
        check("br_r5", dut.regs[5], 32'h77);
        check("br_r6", dut.regs[6], 32'd3);
        check("br_retired", retired, 32'd3);
        check("br_stalls", stalls, 32'd0);

        // Not-taken BNEQZ falls through
        hold_reset();
        dut.regs[5] = 32'h77;
        dut.mem[0] = 32'h34200001;
        dut.mem[1] = 32'h28050001;
        dut.mem[2] = HLT;
        go();
        run_to_halt(edges);
        check("bn_r5", dut.regs[5], 32'd1);
        check("bn_retired", retired, 32'd3);

        // ALU ops, immediate forms, store forwarding and load back
        hold_reset();
        dut.regs[1] = 32'd7; dut.regs[2] = 32'hFFFFFFFD;
        for (int r = 3; r <= 12; r++) dut.regs[r] = 32'hDEAD;
        dut.mem[0]  = 32'h04221800;
        dut.mem[1]  = 32'h08222000;
        dut.mem[2]  = 32'h0C222800;
        dut.mem[3]  = 32'h10413000;
        dut.mem[4]  = 32'h14224800;
        dut.mem[5]  = 32'h302AFFFF;
        dut.mem[6]  = 32'h2C2B0003;
        dut.mem[7]  = 32'h240B0032;
        dut.mem[8]  = 32'h200C0032;
        dut.mem[9]  = HLT;
        go();
        run_to_halt(edges);
        check("alu_sub", dut.regs[3], 32'd10);
        check("alu_and", dut.regs[4], 32'd5);
        check("alu_or", dut.regs[5], 32'hFFFFFFFF);
        check("alu_slt", dut.regs[6], 32'd1);
        check("alu_mul", dut.regs[9], 32'hFFFFFFEB);
        check("alu_slti", dut.regs[10], 32'd0);
        check("alu_subi", dut.regs[11], 32'd4);
        check("alu_sw", dut.mem[50], 32'd4);
        check("alu_lw", dut.regs[12], 32'd4);
        check("alu_retired", retired, 32'd10);
        check("alu_stalls", stalls, EXP_ALU_S);

        // HLT squashes younger instructions and freezes the core
        hold_reset();
        dut.regs[7] = 32'h55;
        dut.mem[0] = HLT;
        dut.mem[1] = 32'h28070009;
        dut.mem[2] = 32'h24070028;
        dut.mem[40] = 32'h1234;
        go();
        run_to_halt(edges);
        pc_snap = pc;
        repeat (20) @(posedge clk);
        #1;
        check("hs_pc", {22'b0, pc}, 32'd1);
        check("hs_pc_frozen", {22'b0, pc}, {22'b0, pc_snap});
        check("hs_retired", retired, 32'd1);
        check("hs_halted", {31'b0, halted}, 32'd1);
        check("hs_r7", dut.regs[7], 32'h55);
        check("hs_mem", dut.mem[40], 32'h1234);

        // Reset asserted mid-run during a load-use stall, then rerun
        hold_reset();
        check("hs_rst_halted", {31'b0, halted}, 32'd0);
        dut.regs[1] = 32'd20; dut.regs[2] = 32'd0; dut.regs[3] = 32'd0;
        dut.mem[0] = 32'h20220000;
        dut.mem[1] = 32'h00421800;
        dut.mem[2] = HLT;
        dut.mem[20] = 32'd7;
        go();
        repeat (3) @(posedge clk);
        #1;
        check("mr_stalls_pre", stalls, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_pc", {22'b0, pc}, 32'd0);
        check("mr_halted", {31'b0, halted}, 32'd0);
        check("mr_retired", retired, 32'd0);
        check("mr_stalls", stalls, 32'd0);
        check("mr_reg_kept", dut.regs[1], 32'd20);
        go();
        run_to_halt(edges);
        check("mr_r3", dut.regs[3], 32'd14);
        check("mr_stalls_run", stalls, EXP_LU);
        check("mr_retired_run", retired, 32'd3);

        // R0 writes discarded, no hazard through R0
        hold_reset();
        dut.regs[0] = 32'd0; dut.regs[8] = 32'h99;
        dut.mem[0] = 32'h28000005;
        dut.mem[1] = 32'h00004000;
        dut.mem[2] = HLT;
        go();
        run_to_halt(edges);
        check("r0_r8", dut.regs[8], 32'd0);
        check("r0_r0", dut.regs[0], 32'd0);
        check("r0_stalls", stalls, 32'd0);
        check("r0_retired", retired, 32'd3);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
